// File: rtl/ft_recovery_ctrl.sv
// Recovery sequencer for the dual-core lockstep pair.
// On a lockstep error it halts both cores and waits for them to quiesce.
// It then copies x1..x(NUM_REGS-1) from the trusted core into the other core,
// verifies the two register files match (retrying a bounded number of times),
// and releases the cores. Failures to quiesce or to converge park the block in
// a sticky FAIL state that only reset clears.
module ft_recovery_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int HALT_TIMEOUT = 16,
    parameter int MAX_RETRY    = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              error_i,
    input  logic              good_core_i,
    input  logic [1:0]        core_idle_i,
    output logic              halt_o,
    output logic              resume_o,
    output logic              src_sel_o,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_src_i,
    input  logic [DATA_W-1:0] rf_rdata_dst_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              busy_o,
    output logic              fail_o,
    output logic [CNT_W-1:0]  error_count_o
);

    // Counter widths; the retry counter is sized so MAX_RETRY=0 still works.
    localparam int TMO_W   = $clog2(HALT_TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [ADDR_W-1:0]  FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(HALT_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_COPY,
        S_VERIFY,
        S_RESUME,
        S_FAIL
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    idx;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 good_core;
    logic                 pass_mismatch;
    logic                 lane_mismatch;

    // Register-file access decode: addresses only leave zero while copying or verifying.
    assign lane_mismatch = (rf_rdata_src_i != rf_rdata_dst_i);
    assign rf_raddr_o    = (state == S_COPY || state == S_VERIFY) ? idx : '0;
    assign rf_waddr_o    = (state == S_COPY) ? idx : '0;
    assign rf_wdata_o    = (state == S_COPY) ? rf_rdata_src_i : '0;
    assign src_sel_o     = (state != S_IDLE && state != S_FAIL) ? good_core : 1'b0;

    // Recovery FSM with registered control outputs updated on each transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            idx           <= FIRST_IDX;
            retry_cnt     <= '0;
            tmo_cnt       <= '0;
            good_core     <= 1'b0;
            pass_mismatch <= 1'b0;
            halt_o        <= 1'b0;
            resume_o      <= 1'b0;
            rf_we_o       <= 1'b0;
            busy_o        <= 1'b0;
            fail_o        <= 1'b0;
            error_count_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (error_i) begin
                        state     <= S_HALT;
                        good_core <= good_core_i;
                        tmo_cnt   <= '0;
                        halt_o    <= 1'b1;
                        busy_o    <= 1'b1;
                        if (error_count_o != '1) begin
                            error_count_o <= error_count_o + CNT_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    if (core_idle_i == 2'b11) begin
                        state   <= S_COPY;
                        idx     <= FIRST_IDX;
                        rf_we_o <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state  <= S_FAIL;
                        busy_o <= 1'b0;
                        fail_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_COPY: begin
                    if (idx == LAST_IDX) begin
                        state         <= S_VERIFY;
                        idx           <= FIRST_IDX;
                        pass_mismatch <= 1'b0;
                        rf_we_o       <= 1'b0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                S_VERIFY: begin
                    if (idx == LAST_IDX) begin
                        if (!(pass_mismatch || lane_mismatch)) begin
                            state    <= S_RESUME;
                            halt_o   <= 1'b0;
                            resume_o <= 1'b1;
                        end else if (retry_cnt < RETRY_MAX) begin
                            state     <= S_COPY;
                            idx       <= FIRST_IDX;
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            rf_we_o   <= 1'b1;
                        end else begin
                            state  <= S_FAIL;
                            busy_o <= 1'b0;
                            fail_o <= 1'b1;
                        end
                    end else begin
                        idx <= idx + ADDR_W'(1);
                        if (lane_mismatch) begin
                            pass_mismatch <= 1'b1;
                        end
                    end
                end
                S_RESUME: begin
                    state     <= S_IDLE;
                    resume_o  <= 1'b0;
                    busy_o    <= 1'b0;
                    retry_cnt <= '0;
                end
                S_FAIL: begin
                    state <= S_FAIL;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
